// File: rtl/spi_word_pkg.sv
// Shared word geometry and types for the SPI word peripheral.
package spi_word_pkg;

    localparam int WORD_BITS      = 64;
    localparam int BYTE_BITS      = 8;
    localparam int BYTES_PER_WORD = 8;

    typedef logic [WORD_BITS-1:0] spi_word_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall
// detection taken from the last two synchronised samples.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchroniser chain and keep one extra sample for edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_word.sv
// SPI mode-0 peripheral moving 64-bit words. Bytes travel LSB-byte first,
// each byte MSB first. All pins are oversampled in the clk domain.
module spi_word
    import spi_word_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 SCK,
    input  logic                 CS,
    input  logic                 COPI,
    output logic                 CIPO,
    input  logic [WORD_BITS-1:0] word_send_data,
    output logic                 word_received,
    output logic [WORD_BITS-1:0] word_data_received
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic copi_s, copi_rise, copi_fall;
    logic unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .resetn(resetn), .d_i(SCK),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .resetn(resetn), .d_i(CS),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // COPI shares the chain depth of SCK so the sample seen on an SCK rise
    // is the bit the host held stable across that edge.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .resetn(resetn), .d_i(COPI),
        .q_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    assign unused_edges = cs_rise ^ cs_fall ^ copi_rise ^ copi_fall;

    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [2:0]            byte_cnt_q, byte_cnt_d;
    logic [BYTE_BITS-1:0]  byte_q, byte_d;
    spi_word_t             asm_q, asm_d;
    spi_word_t             tx_q, tx_d;
    spi_word_t             rx_word_q, rx_word_d;
    logic                  strobe_q, strobe_d;
    logic                  cipo_q, cipo_d;

    logic                  selected;
    logic                  capture;
    logic                  at_boundary;
    logic [BYTE_BITS-1:0]  new_byte;

    assign selected    = ~cs_s;
    assign capture     = sck_rise & selected;
    assign at_boundary = (bit_cnt_q == 3'd0) && (byte_cnt_q == 3'd0);
    assign new_byte    = {byte_q[BYTE_BITS-2:0], copi_s};

    // Next-state for counters, assembly, transmit word and CIPO.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        byte_d     = byte_q;
        asm_d      = asm_q;
        tx_d       = tx_q;
        rx_word_d  = rx_word_q;
        strobe_d   = 1'b0;
        cipo_d     = cipo_q;

        // The outgoing word is only latched between words so a mid-word
        // change of word_send_data waits for the next word.
        if (at_boundary && !sck_rise) begin
            tx_d = word_send_data;
        end

        if (!selected) begin
            // Deselect abandons any partial word; the received output is kept.
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            cipo_d     = 1'b0;
        end else begin
            if (capture) begin
                byte_d    = new_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    asm_d[{byte_cnt_q, 3'b000} +: BYTE_BITS] = new_byte;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        rx_word_d = {new_byte, asm_q[WORD_BITS-BYTE_BITS-1:0]};
                        strobe_d  = 1'b1;
                    end
                end
            end

            // {byte, ~bit} is the wire-order index 8*byte + (7 - bit).
            if (sck_fall) begin
                cipo_d = tx_q[{byte_cnt_q, ~bit_cnt_q}];
            end else if (at_boundary && !sck_s) begin
                cipo_d = tx_q[7];
            end
        end
    end

    // State registers; reset returns every register to zero at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            byte_q     <= '0;
            asm_q      <= '0;
            tx_q       <= '0;
            rx_word_q  <= '0;
            strobe_q   <= 1'b0;
            cipo_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            byte_q     <= byte_d;
            asm_q      <= asm_d;
            tx_q       <= tx_d;
            rx_word_q  <= rx_word_d;
            strobe_q   <= strobe_d;
            cipo_q     <= cipo_d;
        end
    end

    assign CIPO               = cipo_q;
    assign word_received      = strobe_q;
    assign word_data_received = rx_word_q;

endmodule

// File: tb/tb_spi_word.sv
// Directed self-checking bench for spi_word.
module tb_spi_word;

    logic        clk;
    logic        resetn;
    logic        SCK;
    logic        CS;
    logic        COPI;
    logic        CIPO;
    logic [63:0] word_send_data;
    logic        word_received;
    logic [63:0] word_data_received;

    int checks;
    int errors;
    int strobes;
    logic [63:0] rxq[$];

    spi_word #(.SYNC_STAGES(2)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .SCK                (SCK),
        .CS                 (CS),
        .COPI               (COPI),
        .CIPO               (CIPO),
        .word_send_data     (word_send_data),
        .word_received      (word_received),
        .word_data_received (word_data_received)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: counts high cycles of word_received and logs the data.
    always @(posedge clk) begin
        #1;
        if (word_received === 1'b1) begin
            strobes++;
            rxq.push_back(word_data_received);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Send the first nbits of w in wire order; CIPO is captured at each raw SCK rise.
    task automatic send_bits(input logic [63:0] w, input int nbits, input int half,
                             output logic [63:0] cap);
        int idx;
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = 8 * (i / 8) + (7 - (i % 8));
            COPI = w[idx];
            repeat (half) @(negedge clk);
            SCK = 1'b1;
            cap[idx] = CIPO;
            repeat (half) @(negedge clk);
            SCK = 1'b0;
        end
    endtask

    logic [7:0]  t1_bytes [8];
    logic [7:0]  tx_bytes [8];
    logic [63:0] w;
    logic [63:0] cap;
    int          base;

    initial begin
        checks = 0;
        errors = 0;
        strobes = 0;
        resetn = 1'b0;
        SCK = 1'b0;
        CS = 1'b0;
        COPI = 1'b0;
        word_send_data = 64'h0;
        t1_bytes = '{8'hef, 8'hbe, 8'had, 8'hde, 8'had, 8'hde, 8'hef, 8'hbe};
        tx_bytes = '{8'hff, 8'hff, 8'h5f, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_strobe", {63'd0, word_received}, 64'd0);
        chk("reset_data", word_data_received, 64'd0);
        chk("reset_cipo", {63'd0, CIPO}, 64'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Single word at clk/4 from explicit wire bytes.
        for (int k = 0; k < 8; k++) w[8*k +: 8] = t1_bytes[k];
        send_bits(w, 64, 2, cap);
        repeat (2) @(negedge clk);
        chk("t1_strobes", strobes, 1);
        chk("t1_data", word_data_received, 64'hbeefdeaddeadbeef);

        // Three back-to-back words without CS toggling.
        base = strobes;
        rxq.delete();
        send_bits(64'hbeefdeaddeadbeef, 64, 2, cap);
        send_bits(64'h00000000005fffff, 64, 2, cap);
        send_bits(64'h00000110a0000000, 64, 2, cap);
        repeat (2) @(negedge clk);
        chk("b2b_strobes", strobes - base, 3);
        chk("b2b_w0", (rxq.size() > 0) ? rxq[0] : 64'hx, 64'hbeefdeaddeadbeef);
        chk("b2b_w1", (rxq.size() > 1) ? rxq[1] : 64'hx, 64'h00000000005fffff);
        chk("b2b_w2", (rxq.size() > 2) ? rxq[2] : 64'hx, 64'h00000110a0000000);
        CS = 1'b1;
        repeat (10) @(negedge clk);
        chk("b2b_cs_high_no_strobe", strobes - base, 3);

        // Transmit path: CIPO bytes observed at SCK rises.
        word_send_data = 64'h00000000005fffff;
        repeat (4) @(negedge clk);
        chk("tx_cipo_cs_high", {63'd0, CIPO}, 64'd0);
        CS = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(64'h1122334455667788, 64, 8, cap);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 8; k++) chk($sformatf("tx_byte%0d", k), {56'd0, cap[8*k +: 8]}, {56'd0, tx_bytes[k]});
        chk("tx_rx_data", word_data_received, 64'h1122334455667788);
        CS = 1'b1;
        repeat (6) @(negedge clk);
        chk("tx_cipo_after_cs", {63'd0, CIPO}, 64'd0);

        // Partial word abandoned by CS, then a full word.
        CS = 1'b0;
        repeat (6) @(negedge clk);
        base = strobes;
        send_bits(64'hffffffffffffffff, 20, 2, cap);
        CS = 1'b1;
        repeat (8) @(negedge clk);
        chk("partial_no_strobe", strobes - base, 0);
        chk("partial_data_kept", word_data_received, 64'h1122334455667788);
        CS = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(64'h0123456789abcdef, 64, 2, cap);
        repeat (2) @(negedge clk);
        chk("partial_then_full_strobe", strobes - base, 1);
        chk("partial_then_full_data", word_data_received, 64'h0123456789abcdef);

        // Reset mid-word.
        send_bits(64'h5555555555555555, 30, 2, cap);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_strobe", {63'd0, word_received}, 64'd0);
        chk("midreset_data", word_data_received, 64'd0);
        chk("midreset_cipo", {63'd0, CIPO}, 64'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        base = strobes;
        send_bits(64'hcafef00d12345678, 64, 2, cap);
        repeat (2) @(negedge clk);
        chk("after_reset_strobe", strobes - base, 1);
        chk("after_reset_data", word_data_received, 64'hcafef00d12345678);

        // SCK activity while deselected must be ignored.
        CS = 1'b1;
        repeat (6) @(negedge clk);
        base = strobes;
        send_bits(64'hffffffffffffffff, 64, 2, cap);
        repeat (4) @(negedge clk);
        chk("cs_high_sck_no_strobe", strobes - base, 0);
        CS = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(64'h8000000000000001, 64, 2, cap);
        repeat (2) @(negedge clk);
        chk("cs_high_sck_then_strobe", strobes - base, 1);
        chk("cs_high_sck_then_data", word_data_received, 64'h8000000000000001);
        CS = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
